// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU encodings: sequencer states, in_sel codes and one-hot op selects
package alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CAPT,
    ST_DONE,
    ST_ABRT
  } seq_state_t;

  localparam logic [2:0] SEL_NONE    = 3'b000;
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  localparam logic [6:0] OP_ADD = 7'b1000000;
  localparam logic [6:0] OP_SUB = 7'b0100000;
  localparam logic [6:0] OP_MUL = 7'b0010000;
  localparam logic [6:0] OP_AND = 7'b0001000;
  localparam logic [6:0] OP_OR  = 7'b0000100;
  localparam logic [6:0] OP_XOR = 7'b0000010;
  localparam logic [6:0] OP_NOT = 7'b0000001;

  function automatic logic is_onehot(input logic [6:0] op);
    return (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// rtl/alu_prog_mem.sv - program regfile: one write port, one asynchronous read port, never cleared
module alu_prog_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [2*W+6:0]    wdata,
  input  logic [AW-1:0]     raddr,
  output logic [2*W+6:0]    rdata
);

  logic [2*W+6:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues preloaded operand/op entries to the ALU and streams results back
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_num1,
  input  logic [W-1:0]  wr_num2,
  input  logic [6:0]    wr_op,
  input  logic [AW:0]   count,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  alu_out,
  output logic          alu_on,
  output logic [2:0]    alu_in_sel,
  output logic [W-1:0]  alu_num1,
  output logic [W-1:0]  alu_num2,
  output logic [6:0]    alu_op,
  output logic          res_valid,
  output logic [AW-1:0] res_idx,
  output logic [W-1:0]  res_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_cnt
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  seq_state_t     state;
  logic [AW:0]    n;
  logic [AW-1:0]  idx;
  logic [CW-1:0]  wcnt;
  logic [2*W+6:0] entry;
  logic [W-1:0]   e_num1;
  logic [W-1:0]   e_num2;
  logic [6:0]     e_op;
  logic [AW:0]    n_clip;
  logic           last;
  logic           running;

  alu_prog_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata ({wr_num1, wr_num2, wr_op}),
    .raddr (idx),
    .rdata (entry)
  );

  assign {e_num1, e_num2, e_op} = entry;
  assign n_clip  = (count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
  assign last    = ({1'b0, idx} == n - 1'b1);
  assign running = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_CAPT);

  // Outputs are registered actions of the state being left, so the ALU sees load one cycle after LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      n          <= '0;
      idx        <= '0;
      wcnt       <= '0;
      alu_on     <= 1'b0;
      alu_in_sel <= SEL_NONE;
      alu_num1   <= '0;
      alu_num2   <= '0;
      alu_op     <= '0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (running && abort) begin
        state      <= ST_ABRT;
        alu_in_sel <= SEL_RESET;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              n       <= n_clip;
              idx     <= '0;
              err_cnt <= '0;
              busy    <= 1'b1;
              state   <= (n_clip == '0) ? ST_DONE : ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (!is_onehot(e_op)) begin
              err_cnt <= err_cnt + (AW+1)'(1);
              if (last) state <= ST_DONE;
              else begin
                idx   <= idx + 1'b1;
                state <= ST_LOAD;
              end
            end else begin
              alu_on     <= 1'b1;
              alu_in_sel <= SEL_LOAD;
              alu_num1   <= e_num1;
              alu_num2   <= e_num2;
              alu_op     <= e_op;
              wcnt       <= CW'(LAT - 1);
              state      <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            alu_in_sel <= SEL_PERSIST;
            if (wcnt == '0) state <= ST_CAPT;
            else wcnt <= wcnt - 1'b1;
          end
          ST_CAPT: begin
            res_data  <= alu_out;
            res_idx   <= idx;
            res_valid <= 1'b1;
            if (last) state <= ST_DONE;
            else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end
          ST_DONE: begin
            done       <= 1'b1;
            busy       <= 1'b0;
            alu_on     <= 1'b0;
            alu_in_sel <= SEL_NONE;
            state      <= ST_IDLE;
          end
          ST_ABRT: begin
            alu_on     <= 1'b0;
            alu_in_sel <= SEL_NONE;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with an adder ALU stub
module tb_alu_op_sequencer;

  localparam int W = 8, DEPTH = 8, AW = 3, LAT = 1;

  logic          clk = 1'b0, rst = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_num1 = '0, wr_num2 = '0;
  logic [6:0]    wr_op = '0;
  logic [AW:0]   count = '0;
  logic [W-1:0]  alu_out = '0;
  logic          alu_on, res_valid, busy, done;
  logic [2:0]    alu_in_sel;
  logic [W-1:0]  alu_num1, alu_num2, res_data;
  logic [6:0]    alu_op;
  logic [AW-1:0] res_idx;
  logic [AW:0]   err_cnt;

  alu_op_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_num1(wr_num1),
    .wr_num2(wr_num2), .wr_op(wr_op), .count(count), .start(start), .abort(abort),
    .alu_out(alu_out), .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_num1(alu_num1),
    .alu_num2(alu_num2), .alu_op(alu_op), .res_valid(res_valid), .res_idx(res_idx),
    .res_data(res_data), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // ALU stub: result of a load appears one cycle after the load edge
  always @(posedge clk) if (alu_on && alu_in_sel == 3'b010) alu_out <= alu_num1 + alu_num2;

  typedef struct { int idx; int data; } res_t;
  res_t exp_q[$];
  res_t e;
  int   exp_done[$];
  int   strobe_cyc[$];
  int   m_n1[DEPTH], m_n2[DEPTH], m_op[DEPTH];
  int   cyc = 0, done_cnt = 0, done_cyc = 0, n_cmp = 0, n_mis = 0;
  bit   on_seen = 1'b0;
  int   s, d0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (alu_on) on_seen = 1'b1;
      if (res_valid) begin
        strobe_cyc.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_res_valid", res_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          check("res_idx", res_idx, e.idx);
          check("res_data", res_data, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) check("unexpected_done", done, 1'b0);
        else check("err_cnt", err_cnt, exp_done.pop_front());
      end
    end
  end

  task automatic wr(input int a, input int n1, input int n2, input int op);
    m_n1[a] = n1; m_n2[a] = n2; m_op[a] = op;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_num1 = n1[W-1:0]; wr_num2 = n2[W-1:0]; wr_op = op[6:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected results come straight from the program model: valid one-hot entries yield (a+b) mod 256.
  task automatic run(input int cnt, output int st, input int wa = -1, input int stop_at = -1);
    int n, lim, errs;
    n = (cnt > DEPTH) ? DEPTH : cnt;
    lim = (stop_at >= 0) ? stop_at : n;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if ($countones(m_op[i]) != 1) errs++;
      else if (i < lim) exp_q.push_back('{idx: i, data: (m_n1[i] + m_n2[i]) % 256});
    end
    if (stop_at < 0) exp_done.push_back(errs);
    strobe_cyc.delete();
    @(negedge clk);
    count = cnt[AW:0];
    start = 1'b1;
    if (wa >= 0) begin
      wr_en = 1'b1; wr_addr = wa[AW-1:0];
      wr_num1 = m_n1[wa][W-1:0]; wr_num2 = m_n2[wa][W-1:0]; wr_op = m_op[wa][6:0];
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    st = cyc;
  endtask

  task automatic wait_done(input string tag);
    int d;
    d = done_cnt;
    for (int k = 0; k < 300 && done_cnt == d; k++) @(posedge clk);
    check({tag, "_done_seen"}, done_cnt - d, 1);
    @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int t);
    for (int k = 0; k < 1000 && cyc < t; k++) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_alu_on", alu_on, 0);
    check("rst_in_sel", alu_in_sel, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b1;

    // single add entry, latency of strobe and done
    wr(0, 'h57, 'h1A, 'b1000000);
    run(1, s);
    wait_done("t1");
    check("t1_first_strobe", (strobe_cyc.size() > 0) ? strobe_cyc[0] - s : -1, LAT + 2);
    check("t1_done_cycle", done_cyc - s, LAT + 3);
    check("t1_busy_after", busy, 0);

    // three entries with wrap; entry 2 written on the start cycle
    wr(0, 2, 4, 'b1000000);
    wr(1, 7, 2, 'b1000000);
    m_n1[2] = 'hFF; m_n2[2] = 'h01; m_op[2] = 'b1000000;
    run(3, s, 2);
    wait_done("t2");
    check("t2_strobes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("t2_spacing0", strobe_cyc[1] - strobe_cyc[0], LAT + 2);
      check("t2_spacing1", strobe_cyc[2] - strobe_cyc[1], LAT + 2);
    end

    // bad op skipped
    wr(1, 7, 2, 'b0000011);
    run(3, s);
    wait_done("t3");
    check("t3_strobes", strobe_cyc.size(), 2);

    // empty run
    on_seen = 1'b0;
    run(0, s);
    wait_done("t4_zero");
    check("t4_zero_done_cycle", done_cyc - s, 1);
    check("t4_zero_no_alu_on", on_seen, 0);

    // randomized programs and counts
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++)
        wr(i, $urandom_range(0, 255), $urandom_range(0, 255),
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : (1 << $urandom_range(0, 6)));
      run($urandom_range(0, 15), s);
      wait_done("rand");
    end

    // clipped count
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom_range(0, 255), $urandom_range(0, 255), 1 << (i % 7));
    run(15, s);
    wait_done("t4_clip");
    check("t4_clip_strobes", strobe_cyc.size(), DEPTH);

    // all entries bad
    for (int i = 0; i < DEPTH; i++) wr(i, i, i, 0);
    run(DEPTH, s);
    wait_done("all_bad");
    check("all_bad_strobes", strobe_cyc.size(), 0);

    // abort during WAIT of entry 1, with a mid-run start and write that must be dropped
    for (int i = 0; i < 4; i++) wr(i, 2 * i + 1, 2 * i + 2, 'b1000000);
    run(4, s, -1, 1);
    d0 = done_cnt;
    wait_cyc(s + 1);
    start = 1'b1; wr_en = 1'b1; wr_addr = 2; wr_num1 = 'hAA; wr_num2 = 'hBB; wr_op = 'b1000000;
    wait_cyc(s + 2);
    start = 1'b0; wr_en = 1'b0;
    wait_cyc(s + 4);
    abort = 1'b1;
    wait_cyc(s + 5);
    abort = 1'b0;
    check("t5_in_sel_reset", alu_in_sel, 3'b001);
    check("t5_busy_low", busy, 0);
    wait_cyc(s + 6);
    check("t5_in_sel_cleared", alu_in_sel, 0);
    wait_cyc(s + 16);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_strobes", strobe_cyc.size(), 1);

    // start and abort together in IDLE
    strobe_cyc.delete();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t5_start_abort_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("t5_start_abort_idle", busy, 0);

    // rerun shows entry 2 untouched by the dropped write
    run(4, s);
    wait_done("t5_rerun");

    // async reset in WAIT
    wr(0, 'h10, 'h20, 'b1000000);
    wr(1, 'h30, 'h40, 'b0100000);
    run(2, s, -1, 0);
    wait_cyc(s + 1);
    rst = 1'b0;
    #1;
    check("t6_alu_on", alu_on, 0);
    check("t6_in_sel", alu_in_sel, 0);
    check("t6_num1", alu_num1, 0);
    check("t6_busy", busy, 0);
    check("t6_res_data", res_data, 0);
    exp_q.delete();
    exp_done.delete();
    @(negedge clk);
    rst = 1'b1;
    run(2, s);
    wait_done("t6_after");
    check("t6_strobes", strobe_cyc.size(), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
